// File: rtl/cnt_sched_pkg.sv
// Shared definitions for the counter scheduler: FSM encoding and the
// width helper used to size requester indices.
package cnt_sched_pkg;

   // State encoding, also visible on the debug state output.
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ABRT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE,
      S_ABRT = ST_ABRT
   } state_t;

   // Number of bits needed to index n items (minimum 1).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/cnt_sched_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// above the pointer, wrapping to index 0.
module rr_pick
   import cnt_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  win,
   output logic             valid
);

   logic [2*N_REQ-1:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   int                 sum;

   // Rotate the request vector so the pointer position lands at bit 0.
   always_comb begin
      req_dbl = {req, req};
      req_rot = N_REQ'(req_dbl >> ptr);
   end

   // Scan the rotated vector from bit 0 and map the hit back to an index.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      sum   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!valid && req_rot[k]) begin
            valid = 1'b1;
            sum   = int'(ptr) + k;
            if (sum >= N_REQ) sum = sum - N_REQ;
            win   = ID_W'(sum);
         end
      end
   end

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one step counter between N_REQ requesters.
//
// Handshake: req[i] is a level request that the agent holds until it sees
// done (done_id == i) or abort; gnt is the registered one-hot answer. A
// requester that drops req while granted (LOAD or RUN) aborts its job.
// tick is a strobe: each high cycle in RUN advances cnt by one step.
module cnt_sched
   import cnt_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int CNT_W = 4,
   parameter int ID_W  = clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       up,
   input  logic [N_REQ*CNT_W-1:0] lim,
   input  logic                   tick,
   output logic [N_REQ-1:0]       gnt,
   output logic [ID_W-1:0]        gnt_id,
   output logic                   busy,
   output logic [CNT_W-1:0]       cnt,
   output logic                   done,
   output logic [ID_W-1:0]        done_id,
   output logic                   abort,
   output logic [2:0]             dbg_state
);

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   gnt_d;
   logic [ID_W-1:0]    gnt_id_d;
   logic [CNT_W-1:0]   cnt_d;
   logic               done_d;
   logic [ID_W-1:0]    done_id_d;
   logic               abort_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic               dir_q, dir_d;
   logic [CNT_W-1:0]   lim_q, lim_d;

   logic [CNT_W-1:0]   lim_a [N_REQ];
   logic [ID_W-1:0]    pick_id;
   logic               pick_valid;
   logic               req_g;
   logic               up_g;
   logic [CNT_W-1:0]   lim_g;
   logic [CNT_W-1:0]   step_val;
   logic [CNT_W-1:0]   term_val;
   logic [ID_W-1:0]    rr_next;

   // Unpack the flat limit bus into one slice per requester.
   for (genvar i = 0; i < N_REQ; i++) begin : g_lim
      assign lim_a[i] = lim[i*CNT_W +: CNT_W];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (rr_q),
      .win   (pick_id),
      .valid (pick_valid)
   );

   // Granted requester's live inputs, next counter step and terminal value.
   always_comb begin
      req_g    = req[gnt_id];
      up_g     = up[gnt_id];
      lim_g    = lim_a[gnt_id];
      step_val = dir_q ? (cnt + 1'b1) : (cnt - 1'b1);
      term_val = dir_q ? lim_q : '0;
      rr_next  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : (gnt_id + 1'b1);
   end

   // Next-state and next-register logic; every target holds by default.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt;
      gnt_id_d  = gnt_id;
      cnt_d     = cnt;
      done_d    = 1'b0;
      done_id_d = done_id;
      abort_d   = 1'b0;
      rr_d      = rr_q;
      dir_d     = dir_q;
      lim_d     = lim_q;
      case (state_q)
         S_IDLE: begin
            if (pick_valid) begin
               gnt_d          = '0;
               gnt_d[pick_id] = 1'b1;
               gnt_id_d       = pick_id;
               state_d        = S_LOAD;
            end
         end
         S_LOAD: begin
            // An early drop wins over loading; cnt stays as it was.
            if (!req_g) begin
               state_d = S_ABRT;
            end else begin
               dir_d   = up_g;
               lim_d   = lim_g;
               cnt_d   = up_g ? '0 : lim_g;
               state_d = (lim_g == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Abort takes priority over a step that would reach terminal.
            if (!req_g) begin
               state_d = S_ABRT;
            end else if (tick) begin
               cnt_d = step_val;
               if (step_val == term_val) state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d    = 1'b1;
            done_id_d = gnt_id;
            gnt_d     = '0;
            rr_d      = rr_next;
            state_d   = S_IDLE;
         end
         S_ABRT: begin
            abort_d = 1'b1;
            gnt_d   = '0;
            rr_d    = rr_next;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt     <= '0;
         gnt_id  <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         done_id <= '0;
         abort   <= 1'b0;
         rr_q    <= '0;
         dir_q   <= 1'b0;
         lim_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         gnt_id  <= gnt_id_d;
         cnt     <= cnt_d;
         done    <= done_d;
         done_id <= done_id_d;
         abort   <= abort_d;
         rr_q    <= rr_d;
         dir_q   <= dir_d;
         lim_q   <= lim_d;
      end
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy      = (state_q == S_LOAD) || (state_q == S_RUN);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_cnt_sched.sv
// Directed and randomized checks of cnt_sched against a job-level model:
// a job of limit L counts 0..L (up) or L..0 (down), consuming L ticks,
// and grants follow round-robin order from a pointer that moves past the
// last served requester.
module tb_cnt_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  up;
   logic [15:0] lim;
   logic        tick;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic [3:0]  cnt;
   logic        done;
   logic [1:0]  done_id;
   logic        abort;
   logic [2:0]  dbg_state;

   int          n_pass  = 0;
   int          n_total = 0;
   int          rr_m    = 0;
   logic [3:0]  cnt_m   = '0;

   cnt_sched #(.N_REQ(4), .CNT_W(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .up        (up),
      .lim       (lim),
      .tick      (tick),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .cnt       (cnt),
      .done      (done),
      .done_id   (done_id),
      .abort     (abort),
      .dbg_state (dbg_state)
   );

   // Clock and global time bound.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Round-robin rule: first requester at or after the pointer, wrapping.
   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   // per < 0: never tick; per == 0: random; per > 0: every per-th cycle.
   function automatic logic pick_tick(input int per, input int c);
      if (per < 0) return 1'b0;
      if (per == 0) return 1'($urandom_range(1));
      return ((c % per) == 0);
   endfunction

   // Serve one job. Called at a falling edge with the DUT idle and req set.
   task automatic serve(input int abort_at, input bit abort_load, input int tick_per,
                        input bit hold, input bit scramble);
      int   w, ticks, cyc;
      int   l_v;
      bit   d, t, aborted;
      w   = model_pick(req, rr_m);
      l_v = int'(lim[w*4 +: 4]);
      d   = up[w];
      tick = pick_tick(tick_per, 1);
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(1 << w));
      chk("gnt_id", 32'(gnt_id), 32'(w));
      chk("busy_load", 32'(busy), 32'd1);
      aborted = 1'b0;
      if (abort_load) begin
         req[w]  = 1'b0;
         aborted = 1'b1;
      end
      tick = pick_tick(tick_per, 1);
      @(negedge clk);
      if (!aborted) begin
         cnt_m = d ? 4'd0 : 4'(l_v);
         chk("load_cnt", 32'(cnt), 32'(cnt_m));
         if (scramble) begin
            up[w]        = ~up[w];
            lim[w*4 +: 4] = 4'($urandom_range(15));
         end
         ticks = 0;
         cyc   = 0;
         while (!aborted && ticks < l_v && cyc < 400) begin
            if (abort_at == ticks) begin
               req[w]  = 1'b0;
               aborted = 1'b1;
               t       = 1'b1;
            end else begin
               t = pick_tick(tick_per, cyc);
            end
            tick = t;
            cyc++;
            @(negedge clk);
            if (!aborted && t) ticks++;
            cnt_m = d ? 4'(ticks) : 4'(l_v - ticks);
            chk("run_cnt", 32'(cnt), 32'(cnt_m));
            chk("run_busy", 32'(busy), 32'(!aborted && ticks < l_v));
         end
         if (cyc >= 400) chk("run_timeout", 32'(ticks), 32'(l_v));
      end
      chk("pre_done", 32'(done), 32'd0);
      chk("pre_abort", 32'(abort), 32'd0);
      chk("cnt_hold", 32'(cnt), 32'(cnt_m));
      tick = pick_tick(tick_per, 0);
      @(negedge clk);
      chk("done", 32'(done), 32'(!aborted));
      chk("abort", 32'(abort), 32'(aborted));
      chk("gnt_clear", 32'(gnt), 32'd0);
      chk("cnt_after", 32'(cnt), 32'(cnt_m));
      if (!aborted) chk("done_id", 32'(done_id), 32'(w));
      rr_m = (w + 1) % 4;
      if (!hold) req[w] = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      up   = '0;
      lim  = '0;
      tick = 1'b0;

      // Reset values.
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_abort", 32'(abort), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Requester 0, up to 3, tick held high.
      up[0] = 1'b1; lim[3:0] = 4'd3; req = 4'b0001;
      serve(-1, 1'b0, 1, 1'b0, 1'b0);

      // Requester 1, down from 5, tick every third cycle.
      up[1] = 1'b0; lim[7:4] = 4'd5; req = 4'b0010;
      serve(-1, 1'b0, 3, 1'b0, 1'b0);

      // All four requesting, limit 1 up: grants rotate.
      up = 4'b1111; lim = 16'h1111; req = 4'b1111;
      for (int j = 0; j < 5; j++) serve(-1, 1'b0, 1, 1'b1, 1'b0);
      req = '0;

      // Zero-length job on requester 2, no ticks.
      lim[11:8] = 4'd0; req = 4'b0100;
      serve(-1, 1'b0, -1, 1'b0, 1'b0);

      // Requester 3 aborts at cnt 4 with tick high; requester 1 is next.
      up[3] = 1'b1; lim[15:12] = 4'd7; up[1] = 1'b1; lim[7:4] = 4'd2;
      req = 4'b1010;
      serve(4, 1'b0, 1, 1'b0, 1'b0);
      serve(-1, 1'b0, 0, 1'b0, 1'b0);

      // Randomized jobs with random aborts and late input changes.
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && $urandom_range(1) == 1) begin
               req[i]        = 1'b1;
               up[i]         = 1'($urandom_range(1));
               lim[i*4 +: 4] = 4'($urandom_range(9));
            end
         end
         if (req == '0) begin
            req[j % 4]        = 1'b1;
            up[j % 4]         = 1'($urandom_range(1));
            lim[(j % 4)*4 +: 4] = 4'($urandom_range(9));
         end
         serve(($urandom_range(3) == 0) ? int'($urandom_range(8)) : -1,
               ($urandom_range(7) == 0), 0, 1'b0, 1'b1);
      end
      req = '0;

      // Reset mid-run: move the pointer, start a job, reset at cnt 2.
      up[1] = 1'b1; lim[7:4] = 4'd0; req = 4'b0010;
      serve(-1, 1'b0, -1, 1'b0, 1'b0);
      lim[7:4] = 4'd7; req = 4'b0010; tick = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_cnt", 32'(cnt), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_gnt_id", 32'(gnt_id), 32'd0);
      chk("arst_cnt", 32'(cnt), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_done_id", 32'(done_id), 32'd0);
      chk("arst_abort", 32'(abort), 32'd0);
      req = '0; tick = 1'b0;
      @(negedge clk);
      rst   = 1'b0;
      rr_m  = 0;
      cnt_m = '0;
      up[0] = 1'b1; lim[3:0] = 4'd2; up[3] = 1'b1; lim[15:12] = 4'd1;
      req = 4'b1001;
      serve(-1, 1'b0, 1, 1'b0, 1'b0);
      serve(-1, 1'b0, 1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cnt_sched.md
Name: cnt_sched

Overview:
Round-robin scheduler that shares one modulo step counter between N_REQ requesters. Each requester asks for a counting job with its own limit and direction. The block grants one requester at a time and runs the shared counter on an external tick strobe, for example the enable from a frequency divider. It reports completion per job and sits between control agents and the shared counter datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 4, counter and limit width
ID_W, 2, requester index width; equals clog2(N_REQ)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-requester job request, level, held until done or abort
up  in  N_REQ  per-requester direction: 1 = count up, 0 = count down
lim  in  N_REQ*CNT_W  per-requester limit; slice i is lim[i*CNT_W +: CNT_W]
tick  in  1  count-advance strobe; one step per high cycle
gnt  out  N_REQ  one-hot grant, registered
gnt_id  out  ID_W  index of the granted requester, registered
busy  out  1  high in states LOAD and RUN
cnt  out  CNT_W  shared counter value
done  out  1  one-cycle pulse when a job completes
done_id  out  ID_W  requester index of the completed job; valid with done
abort  out  1  one-cycle pulse when the granted requester drops req early

Behaviour:
- Reset (async, rst=1): state IDLE; gnt=0; gnt_id=0; busy=0; cnt=0; done=0; done_id=0; abort=0; rr pointer=0.
- The FSM has five states: IDLE, LOAD, RUN, DONE, ABRT.
- IDLE, any req high:
  - Winner = first requester with req set, searching from the rr pointer upward with wrap to 0.
  - gnt and gnt_id are registered for the winner; next state LOAD.
  - No request: stay in IDLE; cnt holds its value.
- LOAD (exactly one cycle):
  - Capture up[w] and lim[w] into internal dir_r and lim_r. Later changes to up or lim are ignored.
  - cnt <= 0 when up=1; cnt <= lim when up=0.
  - lim=0: next state DONE (zero-length job). Otherwise next state RUN.
- RUN:
  - Each cycle with tick=1, cnt steps by 1 (+1 when dir_r=1, -1 when dir_r=0).
  - When the stepped value equals the terminal value (lim_r when up, 0 when down), next state DONE.
  - tick=0: cnt holds.
  - An up job therefore takes lim ticks; a down job also takes lim ticks.
- DONE (one cycle):
  - done=1 and done_id=gnt_id; gnt cleared; rr pointer <= gnt_id+1 modulo N_REQ; next state IDLE.
  - cnt keeps the terminal value until the next LOAD.
- Abort: the granted requester deasserts req in LOAD or RUN.
  - Next state ABRT. In ABRT: abort=1 for one cycle, gnt cleared, cnt frozen, rr pointer advanced as in DONE, next state IDLE.
  - done is not asserted for an aborted job.
- Latency:
  - req rises in IDLE at edge k: gnt is high after edge k+1, cnt is loaded after edge k+2.
  - Minimum turnaround between two jobs: DONE then IDLE, then the new gnt on the following edge.
- Simultaneous events:
  - tick during LOAD, DONE or ABRT is ignored.
  - Abort has priority over terminal detection in the same cycle.
  - Requests from non-granted requesters during a job are only arbitrated in the next IDLE.
- Reset mid-job: immediate return to reset values; no done or abort pulse.
- Width rule: cnt never leaves the range [0, lim_r]; arithmetic is unsigned CNT_W bits with no wrap.

Decomposition:
- Shared package cnt_sched_pkg holds:
  - the state encoding localparams (IDLE=0, LOAD=1, RUN=2, DONE=3, ABRT=4; 3 bits);
  - the ID_W helper function clog2.
- One sub-module is natural: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector and rr pointer. Outputs: winner index and a valid flag.
  - Instantiated once; kept separate so it can be verified exhaustively on its own.
- The counter step/terminal logic stays inline in cnt_sched.

Test Plan:
1. Reset then req=4'b0001, up[0]=1, lim[0]=3, tick held high -> gnt=0001 one cycle after req; cnt goes 0,1,2,3 on successive cycles; done=1, done_id=0 on the cycle after cnt=3.
2. req=4'b0010, up[1]=0, lim[1]=5, tick high every 3rd cycle -> cnt goes 5,4,3,2,1,0, one step per tick; exactly 5 ticks consumed; done_id=1.
3. req=4'b1111 held, each job lim=1 up -> grants rotate 0,1,2,3,0; done_id follows the same order; no requester is granted twice in a row.
4. lim=0 on requester 2 -> sequence LOAD then DONE; done pulses with done_id=2; cnt=0; no tick required.
5. Requester 3 running (lim=7 up, cnt=4), req[3] dropped -> abort=1 for one cycle; done stays 0; cnt stays 4; next grant goes to the next requesting index after 3.
6. Assert rst asynchronously mid-RUN with cnt=2 -> all outputs return to 0 immediately, before the next clk edge; rr pointer returns to 0; after rst release, req=4'b1000 gives gnt_id=3.
